// File: rtl/riscv_pkg.sv
// Shared opcode and ALU function encodings for the RV32 datapath slice.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

endpackage

// File: rtl/riscv_regfile.sv
// 32x32 register file: two combinational read ports, one write port, sync clear.
module riscv_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    input  logic [4:0]  wa_i,
    input  logic        we_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // x0 is forced on read so the write guard is not the only thing keeping it zero.
    assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : regs_q[ra2_i];

endmodule

// File: rtl/riscv_id_ex_dm.sv
// Decode / execute / data-memory slice: regfile reads, immediates, ALU, word RAM.
module riscv_id_ex_dm
    import riscv_pkg::*;
#(
    parameter int DM_WORDS = 1024,
    parameter int DM_AW    = $clog2(DM_WORDS)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ins,
    input  logic [31:0] wd,
    input  logic        reg_write,
    input  logic        alu_src,
    input  logic [2:0]  alu_op,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] imm,
    output logic [31:0] j_target,
    output logic [31:0] branch,
    output logic [31:0] z,
    output logic        zero,
    output logic [31:0] mem_out
);

    riscv_regfile u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1_i (ins[19:15]),
        .ra2_i (ins[24:20]),
        .wa_i  (ins[11:7]),
        .we_i  (reg_write),
        .wd_i  (wd),
        .rd1_o (rd1),
        .rd2_o (rd2)
    );

    // Offsets stay in halfword units; shifting is the PC logic's job.
    assign branch   = {{20{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8]};
    assign j_target = {{12{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21]};

    always_comb begin
        imm = {{20{ins[31]}}, ins[31:20]};
        case (ins[6:0])
            OP_STORE:  imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            OP_BRANCH: imm = branch;
            OP_JAL:    imm = j_target;
            default:   imm = {{20{ins[31]}}, ins[31:20]};
        endcase
    end

    logic [31:0] alu_b;
    assign alu_b = alu_src ? imm : rd2;

    always_comb begin
        z = 32'd0;
        case (alu_op)
            ALU_AND: z = rd1 & alu_b;
            ALU_OR:  z = rd1 | alu_b;
            ALU_ADD: z = rd1 + alu_b;
            ALU_SUB: z = rd1 - alu_b;
            ALU_SLT: z = ($signed(rd1) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: z = 32'd0;
        endcase
    end

    assign zero = (z == 32'd0);

    logic [31:0]      dmem [DM_WORDS];
    logic [DM_AW-1:0] dm_idx;
    logic             dm_addr_unused;

    assign dm_idx         = z[DM_AW+1:2];
    assign dm_addr_unused = ^{z[31:DM_AW+2], z[1:0]};

    // No reset on the array: contents survive rst_n, only writes are blocked.
    always_ff @(posedge clk) begin
        if (rst_n && mem_write) dmem[dm_idx] <= rd2;
    end

    assign mem_out = mem_read ? dmem[dm_idx] : 32'd0;

endmodule

// File: tb/tb_riscv_id_ex_dm.sv
// Directed bench for riscv_id_ex_dm with hand-computed expectations.
module tb_riscv_id_ex_dm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ins, wd;
    logic        reg_write, alu_src, mem_read, mem_write;
    logic [2:0]  alu_op;
    logic [31:0] rd1, rd2, imm, j_target, branch, z, mem_out;
    logic        zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    riscv_id_ex_dm #(.DM_WORDS(1024)) dut (
        .clk(clk), .rst_n(rst_n), .ins(ins), .wd(wd), .reg_write(reg_write),
        .alu_src(alu_src), .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
        .rd1(rd1), .rd2(rd2), .imm(imm), .j_target(j_target), .branch(branch),
        .z(z), .zero(zero), .mem_out(mem_out)
    );

    function automatic logic [31:0] itype(input logic [11:0] im, input logic [4:0] rs1,
                                          input logic [4:0] rd);
        return {im, rs1, 3'b000, rd, 7'h13};
    endfunction

    function automatic logic [31:0] stype(input logic [11:0] im, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'h23};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wreg(input logic [4:0] r, input logic [31:0] v);
        ins = itype(12'd0, 5'd0, r);
        wd = v;
        reg_write = 1'b1;
        tick();
        reg_write = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; ins = '0; wd = '0; reg_write = 0; alu_src = 0;
        alu_op = 3'b010; mem_read = 0; mem_write = 0;
        #1; tick(); tick();
        rst_n = 1'b1;

        // addi x5,x0,5
        ins = 32'h00500293; alu_src = 1'b1; alu_op = 3'b010; #1;
        chk("addi_rd1", rd1, 32'd0);
        chk("addi_imm", imm, 32'd5);
        chk("addi_z", z, 32'd5);
        chk("addi_zero", {31'd0, zero}, 32'd0);
        ins = 32'h00028313; #1;
        chk("reset_x5", rd1, 32'd0);

        ins = 32'h00500293; wd = 32'd5; reg_write = 1'b1; tick(); reg_write = 1'b0;
        ins = 32'h00028313; #1;
        chk("x5_written", rd1, 32'd5);
        chk("addi_x6_z", z, 32'd5);

        ins = itype(12'd0, 5'd0, 5'd0); wd = 32'd7; reg_write = 1'b1; tick(); reg_write = 1'b0;
        #1;
        chk("x0_read", rd1, 32'd0);

        // sub x6,x5,x6 and friends
        wreg(5'd5, 32'd9); wreg(5'd6, 32'd9);
        ins = 32'h40628333; alu_src = 1'b0; alu_op = 3'b110; #1;
        chk("sub_rd2", rd2, 32'd9);
        chk("sub_z", z, 32'd0);
        chk("sub_zero", {31'd0, zero}, 32'd1);
        alu_op = 3'b010; #1;
        chk("add_z", z, 32'd18);
        wreg(5'd5, 32'hFFFF_FFFF); wreg(5'd6, 32'd1);
        ins = 32'h40628333; alu_op = 3'b111; #1;
        chk("slt_neg", z, 32'd1);
        alu_op = 3'b110; #1;
        chk("sub_wrap", z, 32'hFFFF_FFFE);
        alu_op = 3'b001; #1;
        chk("or_z", z, 32'hFFFF_FFFF);
        alu_op = 3'b000; #1;
        chk("and_z", z, 32'd1);
        alu_op = 3'b011; #1;
        chk("undef_op_z", z, 32'd0);
        chk("undef_op_zero", {31'd0, zero}, 32'd1);
        wreg(5'd5, 32'd1); wreg(5'd6, 32'hFFFF_FFFF);
        ins = 32'h40628333; alu_op = 3'b111; #1;
        chk("slt_pos", z, 32'd0);

        // data memory
        wreg(5'd6, 32'h1234);
        ins = stype(12'h010, 5'd6, 5'd0); alu_src = 1'b1; alu_op = 3'b010; #1;
        chk("sw_imm", imm, 32'h10);
        chk("sw_z", z, 32'h10);
        mem_write = 1'b1; tick(); mem_write = 1'b0; mem_read = 1'b1; #1;
        chk("lw_10", mem_out, 32'h1234);
        ins = stype(12'h013, 5'd6, 5'd0); #1;
        chk("lw_13", mem_out, 32'h1234);
        wreg(5'd7, 32'h1000);
        ins = stype(12'h010, 5'd6, 5'd7); #1;
        chk("lw_wrap_z", z, 32'h1010);
        chk("lw_wrap", mem_out, 32'h1234);
        wreg(5'd6, 32'h5678);
        ins = stype(12'h010, 5'd6, 5'd0); mem_read = 1'b1; mem_write = 1'b1; #1;
        chk("rw_old", mem_out, 32'h1234);
        tick(); mem_write = 1'b0; #1;
        chk("rw_new", mem_out, 32'h5678);
        mem_read = 1'b0; #1;
        chk("rd_off", mem_out, 32'd0);

        // immediates
        ins = 32'hFE000CE3; #1;
        chk("beq_branch", branch, 32'hFFFF_FFFC);
        chk("beq_imm", imm, 32'hFFFF_FFFC);
        ins = 32'h0100006F; #1;
        chk("jal_target", j_target, 32'd8);
        chk("jal_imm", imm, 32'd8);
        ins = stype(12'hFF8, 5'd0, 5'd0); #1;
        chk("s_imm_neg", imm, 32'hFFFF_FFF8);

        // reset overrides reg and memory writes
        wreg(5'd5, 32'hAAAA); wreg(5'd6, 32'hBEEF);
        ins = stype(12'h010, 5'd6, 5'd0); wd = 32'h55;
        reg_write = 1'b1; mem_write = 1'b1; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; reg_write = 1'b0; mem_write = 1'b0; mem_read = 1'b1; #1;
        chk("rst_x6", rd2, 32'd0);
        chk("rst_mem_kept", mem_out, 32'h5678);
        ins = itype(12'd0, 5'd16, 5'd0); #1;
        chk("rst_x16", rd1, 32'd0);
        ins = itype(12'd0, 5'd5, 5'd0); #1;
        chk("rst_x5", rd1, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
